// File: rtl/wlan_scrambler_par.sv
// 802.11 frame-synchronous scrambler/descrambler (x^7 + x^4 + 1), DW bits per beat.
// Seeded mode scrambles/descrambles from an explicit seed; recovery mode learns the seed from the SERVICE field.
module wlan_scrambler_par #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [6:0]    seed,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          seed_valid,
  output logic [6:0]    seed_out
);

  localparam logic [2:0] RC_DONE = 3'd7;

  generate
    if ((DW < 1) || (DW > 8)) begin : g_bad_dw
      $error("wlan_scrambler_par: DW must be in the range 1 to 8");
    end
  endgenerate

  // State vector holds {x7..x1}; rc counts recovery bits and sits at 7 in normal operation.
  logic [6:0]    lfsr_r;
  logic [2:0]    rc_r;
  logic          out_valid_r;
  logic [DW-1:0] out_data_r;
  logic          seed_valid_r;
  logic [6:0]    seed_out_r;

  logic [6:0]    base_state_s;
  logic [2:0]    base_rc_s;
  logic [6:0]    next_state_s;
  logic [2:0]    next_rc_s;
  logic [DW-1:0] beat_out_s;
  logic          done_s;
  logic [6:0]    cap_s;

  // Select the state a beat starts from: a start pulse replaces the running frame state.
  always_comb begin
    base_state_s = lfsr_r;
    base_rc_s    = rc_r;
    if (start) begin
      if (mode) begin
        base_state_s = 7'd0;
        base_rc_s    = 3'd0;
      end else begin
        base_state_s = seed;
        base_rc_s    = RC_DONE;
      end
    end else begin
      base_state_s = lfsr_r;
      base_rc_s    = rc_r;
    end
  end

  // Unrolled per-bit LFSR steps; recovery bits shift received data in and output zero.
  always_comb begin
    logic [6:0] st_v;
    logic [2:0] rc_v;
    logic       f_v;
    st_v       = base_state_s;
    rc_v       = base_rc_s;
    f_v        = 1'b0;
    beat_out_s = {DW{1'b0}};
    done_s     = 1'b0;
    cap_s      = 7'd0;
    for (int i = 0; i < DW; i++) begin
      f_v = st_v[6] ^ st_v[3];
      if (rc_v != RC_DONE) begin
        beat_out_s[i] = 1'b0;
        st_v          = {st_v[5:0], in_data[i]};
        rc_v          = rc_v + 3'd1;
        done_s        = done_s | (rc_v == RC_DONE);
        cap_s         = (rc_v == RC_DONE) ? st_v : cap_s;
      end else begin
        beat_out_s[i] = in_data[i] ^ f_v;
        st_v          = {st_v[5:0], f_v};
      end
    end
    next_state_s = st_v;
    next_rc_s    = rc_v;
  end

  // Frame state, output beat and recovered-seed registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r       <= 7'd0;
      rc_r         <= RC_DONE;
      out_valid_r  <= 1'b0;
      out_data_r   <= {DW{1'b0}};
      seed_valid_r <= 1'b0;
      seed_out_r   <= 7'd0;
    end else begin
      out_valid_r  <= in_valid;
      seed_valid_r <= in_valid & done_s;
      if (in_valid) begin
        lfsr_r     <= next_state_s;
        rc_r       <= next_rc_s;
        out_data_r <= beat_out_s;
      end else begin
        lfsr_r     <= base_state_s;
        rc_r       <= base_rc_s;
        out_data_r <= out_data_r;
      end
      if (in_valid && done_s) begin
        seed_out_r <= cap_s;
      end else if (start) begin
        seed_out_r <= 7'd0;
      end else begin
        seed_out_r <= seed_out_r;
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign seed_valid = seed_valid_r;
  assign seed_out   = seed_out_r;

endmodule
